// File: rtl/rv_decode_stage.sv
// RV32I decode stage: IF/ID register, immediate-type select toward an external
// extender, and an ID/EX register with valid/ready handshakes, flush and stall count.
module rv_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  output logic [2:0]  ImmSrc,
  output logic [31:7] Instr,
  input  logic [31:0] ImmExt,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic        ex_illegal,
  output logic [15:0] stall_cnt
);
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_FENCE  = 7'b0001111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_adv;
  logic        if_take;
  logic        id_illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  assign opcode   = id_instr[6:0];
  assign funct3   = id_instr[14:12];
  assign id_adv   = id_valid & (~ex_valid | ex_ready);
  assign if_ready = ~id_valid | id_adv | flush;
  assign if_take  = if_valid & if_ready & ~flush;
  assign Instr    = id_instr[31:7];

  // Immediate-type select; shift-immediates use the 5-bit shamt form.
  always_comb begin
    ImmSrc = 3'b000;
    case (opcode)
      OP_IMM:           if (funct3 == 3'b001 || funct3 == 3'b101) ImmSrc = 3'b100;
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b101;
      default:          ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    id_illegal = 1'b1;
    case (opcode)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: id_illegal = 1'b0;
      default:                               id_illegal = 1'b1;
    endcase
  end

  // IF/ID register; flush discards any fetch offered in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= 32'd0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (if_take) begin
      id_valid <= 1'b1;
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end else if (id_adv) begin
      id_valid <= 1'b0;
    end
  end

  // ID/EX register; illegal opcodes still advance but carry a zero immediate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_imm      <= 32'd0;
      ex_opcode   <= 7'd0;
      ex_funct3   <= 3'd0;
      ex_funct7b5 <= 1'b0;
      ex_rd       <= 5'd0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (id_adv) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_imm      <= id_illegal ? 32'd0 : ImmExt;
      ex_opcode   <= opcode;
      ex_funct3   <= funct3;
      ex_funct7b5 <= id_instr[30];
      ex_rd       <= id_instr[11:7];
      ex_rs1      <= id_instr[19:15];
      ex_rs2      <= id_instr[24:20];
      ex_illegal  <= id_illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (id_valid && !id_adv && !flush && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
